// File: rtl/evr_event_decoder.sv
// EVR event decoder: turns the registered MGT word stream into event strobes, dbus and timestamp, with link supervision.
// Optional timestamp latch on a programmable event code is built when EVR_TS_LATCH_EN is defined.
module evr_event_decoder #(
    parameter int EVENT_IS_MSB     = 1,
    parameter int LINK_TIMEOUT     = 1024,
    parameter int LINK_GOOD_COMMAS = 16
) (
    input  logic        ref_clk,
    input  logic        reset,
    input  logic [15:0] rx_data,
    input  logic [1:0]  rx_charisk,
    input  logic        mgt_reset_done,
    output logic        link_ok,
    output logic [7:0]  event_code,
    output logic        event_strobe,
    output logic [7:0]  dbus_out,
    output logic [31:0] ts_seconds,
    output logic [31:0] ts_count,
    output logic        ts_valid,
    input  logic [7:0]  ts_latch_code,
    input  logic        ts_latch_ack,
    output logic [31:0] ts_latch_sec,
    output logic [31:0] ts_latch_cnt,
    output logic        ts_latch_valid
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(LINK_TIMEOUT);
    localparam logic [7:0]  GOOD_CNT    = 8'(LINK_GOOD_COMMAS);

    typedef enum logic {LINK_DOWN, LINK_UP} link_state_t;

    link_state_t state;
    logic [15:0] rx_data_q;
    logic [1:0]  rx_charisk_q;
    logic        reset_done_q;
    logic [15:0] gap_cnt;
    logic [7:0]  good_cnt;
    logic [31:0] sec_sr;

    logic [7:0]  ev_byte;
    logic        ev_k;
    logic [7:0]  db_byte;
    logic        db_k;
    logic        comma;
    logic        ev_hit;
    logic        db_hit;
    logic        link_drop;

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            rx_data_q    <= '0;
            rx_charisk_q <= '0;
            reset_done_q <= 1'b0;
        end else begin
            rx_data_q    <= rx_data;
            rx_charisk_q <= rx_charisk;
            reset_done_q <= mgt_reset_done;
        end
    end

    always_comb begin
        ev_byte = rx_data_q[15:8];
        ev_k    = rx_charisk_q[1];
        db_byte = rx_data_q[7:0];
        db_k    = rx_charisk_q[0];
        if (EVENT_IS_MSB == 0) begin
            ev_byte = rx_data_q[7:0];
            ev_k    = rx_charisk_q[0];
            db_byte = rx_data_q[15:8];
            db_k    = rx_charisk_q[1];
        end
        comma  = ev_k && (ev_byte == 8'hBC);
        ev_hit = !ev_k && (ev_byte != 8'h00) && link_ok;
        db_hit = !db_k && link_ok;
        // Drop is computed here so the timestamp logic can clear on the same edge link_ok falls.
        link_drop = link_ok && (!reset_done_q || (!comma && gap_cnt == TIMEOUT_CNT - 16'd1));
    end

    // In DOWN, gap_cnt saturates at the timeout so a stale comma is never counted as good.
    always_ff @(posedge ref_clk) begin
        if (reset || !reset_done_q) begin
            state    <= LINK_DOWN;
            link_ok  <= 1'b0;
            gap_cnt  <= '0;
            good_cnt <= '0;
        end else begin
            case (state)
                LINK_DOWN: begin
                    if (comma) begin
                        gap_cnt <= '0;
                        if (gap_cnt < TIMEOUT_CNT) begin
                            if (good_cnt + 8'd1 == GOOD_CNT) begin
                                state    <= LINK_UP;
                                link_ok  <= 1'b1;
                                good_cnt <= '0;
                            end else begin
                                good_cnt <= good_cnt + 8'd1;
                            end
                        end else begin
                            good_cnt <= '0;
                        end
                    end else if (gap_cnt >= TIMEOUT_CNT) begin
                        good_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                LINK_UP: begin
                    if (comma) begin
                        gap_cnt <= '0;
                    end else if (link_drop) begin
                        state    <= LINK_DOWN;
                        link_ok  <= 1'b0;
                        gap_cnt  <= '0;
                        good_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: begin
                    state   <= LINK_DOWN;
                    link_ok <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            event_strobe <= 1'b0;
            event_code   <= '0;
            dbus_out     <= '0;
        end else begin
            event_strobe <= ev_hit;
            if (ev_hit) begin
                event_code <= ev_byte;
            end
            if (db_hit) begin
                dbus_out <= db_byte;
            end
        end
    end

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            sec_sr     <= '0;
            ts_seconds <= '0;
            ts_count   <= '0;
            ts_valid   <= 1'b0;
        end else begin
            if (ev_hit && ev_byte == 8'h7D) begin
                ts_seconds <= sec_sr;
                ts_count   <= '0;
                sec_sr     <= '0;
                ts_valid   <= 1'b1;
            end else begin
                ts_count <= ts_count + 32'd1;
                if (ev_hit && ev_byte == 8'h70) begin
                    sec_sr <= {sec_sr[30:0], 1'b0};
                end else if (ev_hit && ev_byte == 8'h71) begin
                    sec_sr <= {sec_sr[30:0], 1'b1};
                end
            end
            if (link_drop) begin
                ts_valid <= 1'b0;
                sec_sr   <= '0;
            end
        end
    end

`ifdef EVR_TS_LATCH_EN
    logic latch_match;
    assign latch_match = ev_hit && (ev_byte == ts_latch_code);

    // A match concurrent with ack is accepted, so the new capture replaces the acknowledged one.
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            ts_latch_sec   <= '0;
            ts_latch_cnt   <= '0;
            ts_latch_valid <= 1'b0;
        end else if (latch_match && (!ts_latch_valid || ts_latch_ack)) begin
            ts_latch_sec   <= ts_seconds;
            ts_latch_cnt   <= ts_count;
            ts_latch_valid <= 1'b1;
        end else if (ts_latch_ack) begin
            ts_latch_valid <= 1'b0;
        end
    end
`else
    logic unused_latch_inputs;
    assign unused_latch_inputs = ^{ts_latch_code, ts_latch_ack};
    assign ts_latch_sec   = '0;
    assign ts_latch_cnt   = '0;
    assign ts_latch_valid = 1'b0;
`endif

endmodule
